// File: rtl/img2col_reader.sv
// rtl/img2col_reader.sv - im2col patch reader: walks a row-major image in RAM and
// streams K x K stride-1 patches through a 2-entry credit-controlled output buffer.
module img2col_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_SIZE  = 10,
  parameter int IMG_H      = 8,
  parameter int IMG_W      = 8,
  parameter int K          = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_ena,
  output logic                  mem_wea,
  output logic [ADDR_SIZE-1:0]  mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_patch_last,
  output logic                  m_frame_last
);

  localparam int OUT_H = IMG_H - K + 1;
  localparam int OUT_W = IMG_W - K + 1;
  localparam logic [ADDR_SIZE-1:0] K_LAST     = ADDR_SIZE'(K - 1);
  localparam logic [ADDR_SIZE-1:0] OY_LAST    = ADDR_SIZE'(OUT_H - 1);
  localparam logic [ADDR_SIZE-1:0] OX_LAST    = ADDR_SIZE'(OUT_W - 1);
  localparam logic [ADDR_SIZE-1:0] ROW_STRIDE = ADDR_SIZE'(IMG_W);
  localparam logic [ADDR_SIZE-1:0] ONE        = ADDR_SIZE'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_d;
  logic [ADDR_SIZE-1:0] oy_q, oy_d, ox_q, ox_d, ky_q, ky_d, kx_q, kx_d;
  logic inflight_q, inflight_d;
  logic pend_patch_q, pend_patch_d, pend_frame_q, pend_frame_d;
  logic [DATA_WIDTH-1:0] buf_data_q [2];
  logic [DATA_WIDTH-1:0] buf_data_d [2];
  logic [1:0] buf_patch_q, buf_patch_d, buf_frame_q, buf_frame_d;
  logic rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [1:0] count_q, count_d;

  logic issue, pop, push, at_patch_last, at_frame_last;
  logic [1:0] credit_used;

  // Credit counts reads in flight plus buffered entries, net of this cycle's pop,
  // so a read is only issued when its data is guaranteed a free slot.
  always_comb begin
    pop           = (count_q != 2'd0) && m_ready;
    push          = inflight_q;
    credit_used   = {1'b0, inflight_q} + count_q - {1'b0, pop};
    issue         = (state_q == S_RUN) && (credit_used < 2'd2);
    at_patch_last = (ky_q == K_LAST) && (kx_q == K_LAST);
    at_frame_last = at_patch_last && (oy_q == OY_LAST) && (ox_q == OX_LAST);
  end

  always_comb begin
    oy_d = oy_q;
    ox_d = ox_q;
    ky_d = ky_q;
    kx_d = kx_q;
    if (state_q == S_IDLE && start) begin
      oy_d = '0;
      ox_d = '0;
      ky_d = '0;
      kx_d = '0;
    end else if (issue) begin
      if (kx_q != K_LAST) begin
        kx_d = kx_q + ONE;
      end else begin
        kx_d = '0;
        if (ky_q != K_LAST) begin
          ky_d = ky_q + ONE;
        end else begin
          ky_d = '0;
          if (ox_q != OX_LAST) begin
            ox_d = ox_q + ONE;
          end else begin
            ox_d = '0;
            oy_d = (oy_q != OY_LAST) ? oy_q + ONE : '0;
          end
        end
      end
    end
  end

  // Flags travel alongside the read so they land in the buffer with their data.
  always_comb begin
    inflight_d   = issue;
    pend_patch_d = issue ? at_patch_last : pend_patch_q;
    pend_frame_d = issue ? at_frame_last : pend_frame_q;
  end

  always_comb begin
    buf_data_d  = buf_data_q;
    buf_patch_d = buf_patch_q;
    buf_frame_d = buf_frame_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (push) begin
      buf_data_d[wr_ptr_q]  = mem_rdata;
      buf_patch_d[wr_ptr_q] = pend_patch_q;
      buf_frame_d[wr_ptr_q] = pend_frame_q;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (issue && at_frame_last) state_d = S_DRAIN;
      // Leave as the final element is accepted so done lands on the next cycle.
      S_DRAIN: if (!inflight_q && (count_q == {1'b0, pop})) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_q != S_IDLE);
    done         = (state_q == S_DONE);
    mem_ena      = issue;
    mem_wea      = 1'b0;
    mem_addr     = (oy_q + ky_q) * ROW_STRIDE + ox_q + kx_q;
    m_valid      = (count_q != 2'd0);
    m_data       = buf_data_q[rd_ptr_q];
    m_patch_last = m_valid && buf_patch_q[rd_ptr_q];
    m_frame_last = m_valid && buf_frame_q[rd_ptr_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      oy_q          <= '0;
      ox_q          <= '0;
      ky_q          <= '0;
      kx_q          <= '0;
      inflight_q    <= 1'b0;
      pend_patch_q  <= 1'b0;
      pend_frame_q  <= 1'b0;
      buf_data_q[0] <= '0;
      buf_data_q[1] <= '0;
      buf_patch_q   <= '0;
      buf_frame_q   <= '0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      oy_q          <= oy_d;
      ox_q          <= ox_d;
      ky_q          <= ky_d;
      kx_q          <= kx_d;
      inflight_q    <= inflight_d;
      pend_patch_q  <= pend_patch_d;
      pend_frame_q  <= pend_frame_d;
      buf_data_q    <= buf_data_d;
      buf_patch_q   <= buf_patch_d;
      buf_frame_q   <= buf_frame_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

endmodule

// File: tb/tb_img2col_reader.sv
// tb/tb_img2col_reader.sv - self-checking bench for img2col_reader (4x4 K=3 and 2x2 K=1).
module tb_img2col_reader;
  localparam int DW = 8;
  localparam int AW = 10;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          pl;
    logic          fl;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic start_a, busy_a, done_a, ena_a, wea_a, valid_a, ready_a, pl_a, fl_a;
  logic [AW-1:0] addr_a;
  logic [DW-1:0] rdata_a, data_a;
  logic start_b, busy_b, done_b, ena_b, wea_b, valid_b, ready_b, pl_b, fl_b;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] rdata_b, data_b;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t q_a[$];

  img2col_reader #(.DATA_WIDTH(DW), .ADDR_SIZE(AW), .IMG_H(4), .IMG_W(4), .K(3)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .mem_ena(ena_a), .mem_wea(wea_a), .mem_addr(addr_a), .mem_rdata(rdata_a),
    .m_data(data_a), .m_valid(valid_a), .m_ready(ready_a),
    .m_patch_last(pl_a), .m_frame_last(fl_a));

  img2col_reader #(.DATA_WIDTH(DW), .ADDR_SIZE(AW), .IMG_H(2), .IMG_W(2), .K(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .mem_ena(ena_b), .mem_wea(wea_b), .mem_addr(addr_b), .mem_rdata(rdata_b),
    .m_data(data_b), .m_valid(valid_b), .m_ready(ready_b),
    .m_patch_last(pl_b), .m_frame_last(fl_b));

  // RAM models holding mem[i] = i with one cycle of read latency.
  always @(posedge clk) if (ena_a) rdata_a <= addr_a[DW-1:0];
  always @(posedge clk) if (ena_b) rdata_b <= addr_b[DW-1:0];

  task automatic push_frame_a();
    exp_t e;
    for (int oy = 0; oy < 2; oy++)
      for (int ox = 0; ox < 2; ox++)
        for (int ky = 0; ky < 3; ky++)
          for (int kx = 0; kx < 3; kx++) begin
            e.d  = 8'((oy + ky) * 4 + ox + kx);
            e.pl = (ky == 2) && (kx == 2);
            e.fl = e.pl && (oy == 1) && (ox == 1);
            q_a.push_back(e);
          end
  endtask

  task automatic pulse_start_a();
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  // mode 0: ready high, 1: random ready, 2: 10-cycle stall at stall_at accepted elements
  task automatic stream_a(input int mode, input int poke_cyc, input int stall_at,
                          input int abort_at, output int first_valid, output int last_acc,
                          output int n_acc, output logic ena0);
    int cyc, stall_left, outst;
    bit fin_pend, fin, stalled_done, prev_hold, pop;
    exp_t prev, e;
    first_valid = -1; last_acc = -1; n_acc = 0; ena0 = 1'b0;
    fin_pend = 0; fin = 0; stall_left = 0; stalled_done = 0; prev_hold = 0; outst = 0;
    prev = '0;
    for (cyc = 0; cyc < 1000 && !fin; cyc++) begin
      if (abort_at >= 0 && n_acc == abort_at) begin
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy_a, done_a, valid_a, pl_a, fl_a, ena_a, wea_a} !== 7'b0 || addr_a !== '0 || data_a !== '0) begin
          n_bad++;
          $display("FAIL abort_outputs: busy=%b done=%b valid=%b pl=%b fl=%b ena=%b wea=%b addr=%0d data=%0d, required all 0",
                   busy_a, done_a, valid_a, pl_a, fl_a, ena_a, wea_a, addr_a, data_a);
        end
        q_a.delete();
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      case (mode)
        1: ready_a = 1'($urandom_range(0, 1));
        2: begin
          if (!stalled_done && stall_left == 0 && n_acc == stall_at) stall_left = 10;
          ready_a = (stall_left == 0);
        end
        default: ready_a = 1'b1;
      endcase
      start_a = (poke_cyc >= 0) && ((cyc == poke_cyc) || fin_pend);
      #1;
      if (cyc == 0) ena0 = ena_a;
      if (valid_a === 1'b1 && first_valid < 0) first_valid = cyc;
      if (prev_hold) begin
        n_cmp++;
        if (valid_a !== 1'b1 || {data_a, pl_a, fl_a} !== prev) begin
          n_bad++;
          $display("FAIL hold_stable: got valid=%b d=%0d pl=%b fl=%b, required valid=1 d=%0d pl=%b fl=%b",
                   valid_a, data_a, pl_a, fl_a, prev.d, prev.pl, prev.fl);
        end
      end
      n_cmp++;
      if (done_a !== fin_pend) begin
        n_bad++;
        $display("FAIL done_pulse: cyc %0d done=%b, required %b", cyc, done_a, fin_pend);
      end
      if (fin_pend) begin
        fin = 1;
        n_cmp++;
        if (busy_a !== 1'b1) begin
          n_bad++;
          $display("FAIL busy_at_done: got %b, required 1", busy_a);
        end
      end
      pop = (valid_a === 1'b1) && ready_a;
      n_cmp++;
      if (outst + int'(ena_a) - int'(pop) > 2) begin
        n_bad++;
        $display("FAIL credit: outstanding would be %0d, required <= 2", outst + int'(ena_a) - int'(pop));
      end
      outst += int'(ena_a) - int'(pop);
      if (stall_left == 1) begin
        n_cmp++;
        if (ena_a !== 1'b0 || outst != 2) begin
          n_bad++;
          $display("FAIL stall_fill: ena=%b outstanding=%0d, required ena=0 outstanding=2", ena_a, outst);
        end
      end
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) stalled_done = 1;
      end
      if (pop) begin
        n_acc++;
        last_acc = cyc;
        if (q_a.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL extra_element: got d=%0d, required no element", data_a);
        end else begin
          e = q_a.pop_front();
          n_cmp++;
          if (data_a !== e.d || pl_a !== e.pl || fl_a !== e.fl) begin
            n_bad++;
            $display("FAIL element %0d: got d=%0d pl=%b fl=%b, required d=%0d pl=%b fl=%b",
                     n_acc, data_a, pl_a, fl_a, e.d, e.pl, e.fl);
          end
          if (e.fl) fin_pend = 1;
        end
      end
      prev_hold = (valid_a === 1'b1) && !ready_a;
      prev = {data_a, pl_a, fl_a};
      @(negedge clk);
    end
    start_a = 1'b0;
    #1;
    n_cmp++;
    if (!fin) begin
      n_bad++;
      $display("FAIL stream_timeout: accepted %0d, required completion", n_acc);
    end else if (done_a !== 1'b0 || busy_a !== 1'b0) begin
      n_bad++;
      $display("FAIL after_done: done=%b busy=%b, required 0 0", done_a, busy_a);
    end
    n_cmp++;
    if (q_a.size() != 0) begin
      n_bad++;
      $display("FAIL leftover: %0d expected elements not produced, required 0", q_a.size());
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({busy_a, done_a, valid_a, pl_a, fl_a, ena_a, wea_a} !== 7'b0 || addr_a !== '0 || data_a !== '0) begin
      n_bad++;
      $display("FAIL reset_a: busy=%b done=%b valid=%b pl=%b fl=%b ena=%b wea=%b addr=%0d data=%0d, required all 0",
               busy_a, done_a, valid_a, pl_a, fl_a, ena_a, wea_a, addr_a, data_a);
    end
    n_cmp++;
    if ({busy_b, done_b, valid_b, pl_b, fl_b, ena_b, wea_b} !== 7'b0 || addr_b !== '0 || data_b !== '0) begin
      n_bad++;
      $display("FAIL reset_b: busy=%b valid=%b ena=%b addr=%0d data=%0d, required all 0",
               busy_b, valid_b, ena_b, addr_b, data_b);
    end
  endtask

  task automatic test_always_ready();
    int fv, la, na;
    logic e0;
    push_frame_a();
    pulse_start_a();
    stream_a(0, -1, -1, -1, fv, la, na, e0);
    n_cmp++;
    if (e0 !== 1'b1) begin n_bad++; $display("FAIL first_ena: got %b, required 1", e0); end
    n_cmp++;
    if (fv != 2) begin n_bad++; $display("FAIL first_valid_latency: got %0d, required 2", fv); end
    n_cmp++;
    if (na != 36 || la - fv != 35) begin
      n_bad++;
      $display("FAIL consecutive_beats: count=%0d span=%0d, required 36 and 35", na, la - fv);
    end
  endtask

  task automatic test_random_ready();
    int fv, la, na;
    logic e0;
    push_frame_a();
    pulse_start_a();
    stream_a(1, -1, -1, -1, fv, la, na, e0);
    n_cmp++;
    if (na != 36) begin n_bad++; $display("FAIL random_count: got %0d, required 36", na); end
  endtask

  task automatic test_stall();
    int fv, la, na;
    logic e0;
    push_frame_a();
    pulse_start_a();
    stream_a(2, -1, 13, -1, fv, la, na, e0);
    n_cmp++;
    if (na != 36) begin n_bad++; $display("FAIL stall_count: got %0d, required 36", na); end
  endtask

  task automatic test_start_ignored();
    int fv, la, na;
    logic e0;
    push_frame_a();
    pulse_start_a();
    stream_a(0, 10, -1, -1, fv, la, na, e0);
    n_cmp++;
    if (na != 36) begin n_bad++; $display("FAIL start_ignored_count: got %0d, required 36", na); end
  endtask

  task automatic test_back_to_back();
    int fv, la, na;
    logic e0;
    for (int f = 0; f < 2; f++) begin
      push_frame_a();
      pulse_start_a();
      stream_a(0, -1, -1, -1, fv, la, na, e0);
      n_cmp++;
      if (na != 36) begin n_bad++; $display("FAIL back_to_back_count frame %0d: got %0d, required 36", f, na); end
    end
  endtask

  task automatic test_reset_abort();
    int fv, la, na;
    logic e0;
    push_frame_a();
    pulse_start_a();
    stream_a(0, -1, -1, 20, fv, la, na, e0);
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if (done_a !== 1'b0 || busy_a !== 1'b0) begin
        n_bad++;
        $display("FAIL abort_no_done: done=%b busy=%b, required 0 0", done_a, busy_a);
      end
      @(negedge clk);
    end
    push_frame_a();
    pulse_start_a();
    stream_a(0, -1, -1, -1, fv, la, na, e0);
    n_cmp++;
    if (na != 36) begin n_bad++; $display("FAIL restart_count: got %0d, required 36", na); end
  endtask

  task automatic test_k1();
    int idx;
    bit seen_done;
    idx = 0;
    seen_done = 0;
    ready_b = 1'b1;
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int cyc = 0; cyc < 30 && !seen_done; cyc++) begin
      #1;
      if (done_b === 1'b1) begin
        seen_done = 1;
        n_cmp++;
        if (idx != 4) begin n_bad++; $display("FAIL k1_done_count: got %0d, required 4", idx); end
      end
      if (valid_b === 1'b1) begin
        n_cmp++;
        if (data_b !== 8'(idx) || pl_b !== 1'b1 || fl_b !== (idx == 3)) begin
          n_bad++;
          $display("FAIL k1_element %0d: got d=%0d pl=%b fl=%b, required d=%0d pl=1 fl=%b",
                   idx, data_b, pl_b, fl_b, idx, idx == 3);
        end
        idx++;
      end
      @(negedge clk);
    end
    if (!seen_done) begin
      n_cmp++; n_bad++;
      $display("FAIL k1_timeout: accepted %0d, required done", idx);
    end
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; ready_a = 1'b0;
    start_b = 1'b0; ready_b = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_always_ready();
    test_random_ready();
    test_stall();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    test_k1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/img2col_reader.md
# img2col_reader

Upstream consumer of the tensor RAM (`ram_t0`): walks a single-channel IMG_H×IMG_W image stored row-major in the RAM and emits it as an im2col stream of K×K patches (stride 1, no padding) toward the GEMM array. It drives the RAM's single read/write port in read-only mode and absorbs the RAM's 1-cycle read latency. A 2-entry output buffer lets it sustain one element per cycle under valid/ready backpressure.

## Interface
- `DATA_WIDTH`, 8: element width; matches RAM `dina`/`douta`.
- `ADDR_SIZE`, 10: RAM address width; IMG_H*IMG_W <= 2^ADDR_SIZE is required.
- `IMG_H`, 8: image rows.
- `IMG_W`, 8: image columns.
- `K`, 3: kernel size; 1 <= K <= min(IMG_H, IMG_W).

Ports:
- `clk` in 1: single clock, shared with RAM `clka`.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse; begins a frame when idle.
- `busy` out 1: frame in progress.
- `done` out 1: one-cycle pulse after the final element is accepted.
- `mem_ena` out 1: to RAM `ena`.
- `mem_wea` out 1: to RAM `wea`; constant 0.
- `mem_addr` out ADDR_SIZE: to RAM `addra`.
- `mem_rdata` in DATA_WIDTH: from RAM `douta`.
- `m_data` out DATA_WIDTH: stream element.
- `m_valid` out 1: `m_data` valid.
- `m_ready` in 1: consumer accepts when `m_valid && m_ready` at a rising edge.
- `m_patch_last` out 1: marks the element (ky=K-1, kx=K-1) of each patch.
- `m_frame_last` out 1: marks the final element of the frame.

## Operation
- OUT_H = IMG_H-K+1 and OUT_W = IMG_W-K+1. Total elements = OUT_H*OUT_W*K*K.
- Ordering: oy outer, then ox, then ky, then kx innermost. Element = mem[(oy+ky)*IMG_W + ox+kx].
- The address is computed in ADDR_SIZE bits and never wraps, given the parameter constraint.
- FSM states:
  - IDLE: `start` -> RUN, with all counters cleared.
  - RUN: issues reads. After the last address is issued -> DRAIN.
  - DRAIN: waits until no read is in flight and the buffer is empty -> DONE.
  - DONE: pulses `done` for one cycle -> IDLE.
- `start` is ignored in every state except IDLE.
- `busy` = (state != IDLE).
- Read issue rule:
  - `mem_ena` = RUN && (inflight + occupancy - pop < 2), where pop = `m_valid && m_ready`.
  - `mem_ena` and `mem_addr` are combinational from registered state.
  - Counters advance only on an issued read.
- inflight is 1 for the cycle after an issue. `mem_rdata` is written into the buffer on the following edge.
- Each buffer entry carries its data plus both last flags, which are computed at issue time.
- The buffer is a 2-entry FIFO and never overflows, by the credit rule.
- Simultaneous buffer write and pop in the same cycle are both honoured.
- `m_data` and both flags are held stable while `m_valid && !m_ready`.
- `m_patch_last` and `m_frame_last` are qualified by `m_valid`.

## Timing
- Reset: the FSM goes to IDLE and the buffer and inflight counter are flushed.
- Reset values:
  - `busy`, `done`, `m_valid`, `m_patch_last`, `m_frame_last`, `mem_ena`, `mem_wea`: all 0.
  - `mem_addr`, `m_data`: both 0.
- Reset mid-frame aborts immediately. No `done` is produced, and RAM contents are untouched.
- Startup latency:
  - `start` sampled at edge S.
  - First `mem_ena` is high in the cycle after S and is sampled by the RAM at S+1.
  - The buffer captures at S+2, so `m_valid` rises after S+2.
- Throughput: with `m_ready` held high, one element per cycle, with no bubbles across patch or row boundaries.
- Backpressure: with `m_ready` low, at most 2 elements are buffered and issue stalls. Throughput resumes on the first cycle `m_ready` returns.
- Completion: `done` is high in the cycle after the edge at which the `m_frame_last` element is accepted. `busy` falls together with `done`.
- A `start` pulse in the same cycle as `done` is ignored.

## Test plan
All scenarios use IMG_H=IMG_W=4, K=3, mem[i]=i (i=0..15), giving 36 elements.
- `m_ready` always 1: stream is 0,1,2,4,5,6,8,9,10 | 1,2,3,5,6,7,9,10,11 | 4,5,6,8,9,10,12,13,14 | 5,6,7,9,10,11,13,14,15.
  - `m_patch_last` is set on elements 9, 18, 27, 36, and `m_frame_last` on element 36.
  - First `m_valid` appears 2 cycles after the start edge; 36 consecutive beats; `done` one cycle later.
- Random `m_ready` (50%): same sequence, no loss or duplication. `m_data` is stable while stalled, and `mem_ena` never causes more than 2 outstanding elements.
- `m_ready` low for 10 cycles mid-patch: `mem_ena` stops after the buffer fills (2 elements). Output resumes with the correct next value.
- `start` pulsed while busy: ignored, and exactly 36 elements are produced. Two back-to-back frames both produce correct streams.
- `rst` asserted at element 20: all outputs go to 0 asynchronously and `done` never pulses. A subsequent `start` streams from element 0 again.
- K=1, IMG 2×2: stream is 0,1,2,3, with `m_patch_last` set on every element.
